// File: rtl/nco_core.sv
// Quadrature NCO: phase accumulator, quarter-wave folded sine table, three-stage output pipeline.
// Optional macro NCO_DITHER_EN adds LFSR phase dither ahead of the table index truncation.
module nco_core #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    ftw_we,
    input  logic [PHASE_W-1:0]      ftw_in,
    input  logic [PHASE_W-1:0]      poff_in,
    input  logic                    phase_clr,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    out_valid
);

    localparam int  Q   = 2 ** (LUT_AW - 2);
    localparam int  IW  = LUT_AW - 1;
    localparam real PI  = 3.14159265358979323846;
    localparam real AMP = (2.0 ** (OUT_W - 1)) - 1.0;

    // Quarter-wave table, Q+1 entries so both 0 and pi/2 are exact points.
    logic signed [OUT_W-1:0] lut [0:Q];

    for (genvar i = 0; i <= Q; i++) begin : g_lut
        localparam real S = AMP * $sin(PI * i / (2.0 * Q));
        assign lut[i] = OUT_W'($rtoi(S + 0.5));
    end

    function automatic logic [IW-1:0] fold_idx(input logic [LUT_AW-1:0] k);
        logic [IW-1:0] o;
        o = IW'(k[LUT_AW-3:0]);
        return k[LUT_AW-2] ? IW'(Q) - o : o;
    endfunction

    logic [PHASE_W-1:0]      ftw_q, acc_q, acc_d, phase_d;
    logic [LUT_AW-1:0]       ks_q, kc_q, ks_d, kc_d;
    logic                    v1_q, v2_q, vo_q;
    logic signed [OUT_W-1:0] s2_sin_q, s2_cos_q, s2_sin_d, s2_cos_d;
    logic signed [OUT_W-1:0] sin_q, cos_q;

`ifdef NCO_DITHER_EN
    localparam int DW = (PHASE_W - LUT_AW > 16) ? 16 : (PHASE_W - LUT_AW);
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= 16'hACE1;
        else      lfsr_q <= lfsr_d;
    end

    assign phase_d = acc_q + poff_in + PHASE_W'(lfsr_q[DW-1:0]);
`else
    assign phase_d = acc_q + poff_in;
`endif

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        acc_d = acc_q;
        if (phase_clr)  acc_d = '0;
        else if (en)    acc_d = acc_q + ftw_q;
    end

    // Cosine is the sine index advanced a quarter turn.
    assign ks_d = phase_d[PHASE_W-1 -: LUT_AW];
    assign kc_d = ks_d + LUT_AW'(Q);

    always_comb begin
        s2_sin_d = lut[fold_idx(ks_q)];
        s2_cos_d = lut[fold_idx(kc_q)];
        if (ks_q[LUT_AW-1]) s2_sin_d = -s2_sin_d;
        if (kc_q[LUT_AW-1]) s2_cos_d = -s2_cos_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all stages see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ftw_q    <= '0;
            acc_q    <= '0;
            ks_q     <= '0;
            kc_q     <= '0;
            v1_q     <= 1'b0;
            s2_sin_q <= '0;
            s2_cos_q <= '0;
            v2_q     <= 1'b0;
            sin_q    <= '0;
            cos_q    <= '0;
            vo_q     <= 1'b0;
        end else begin
            if (ftw_we) ftw_q <= ftw_in;
            acc_q <= acc_d;
            v1_q  <= en;
            if (en) begin
                ks_q <= ks_d;
                kc_q <= kc_d;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                s2_sin_q <= s2_sin_d;
                s2_cos_q <= s2_cos_d;
            end
            vo_q <= v2_q;
            if (v2_q) begin
                sin_q <= s2_sin_q;
                cos_q <= s2_cos_q;
            end
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = vo_q;

endmodule

// File: tb/tb_nco_core.sv
// Self-checking bench for nco_core: directed scenarios plus randomized traffic against a
// cycle-indexed phase model that evaluates sin/cos directly with real arithmetic.
module tb_nco_core;

    localparam real PI = 3.14159265358979323846;

    logic               clk;
    logic               rst;
    logic               en;
    logic               ftw_we;
    logic [31:0]        ftw_in;
    logic [31:0]        poff_in;
    logic               phase_clr;
    logic signed [15:0] sin_out;
    logic signed [15:0] cos_out;
    logic               out_valid;

    nco_core dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ftw_we    (ftw_we),
        .ftw_in    (ftw_in),
        .poff_in   (poff_in),
        .phase_clr (phase_clr),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_ftw = '0;
    bit          hist_en [0:4095];
    int          hist_k  [0:4095];
    bit          ev    = 1'b0;
    int          es    = 0;
    int          ec    = 0;

    function automatic int round_sym(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    function automatic int ref_sin(input int k);
        return round_sym(32767.0 * $sin(2.0 * PI * real'(k) / 256.0));
    endfunction

    function automatic int ref_cos(input int k);
        return round_sym(32767.0 * $cos(2.0 * PI * real'(k) / 256.0));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the phase model at the edge, then check just after it.
    task automatic step(input bit e, input bit we, input logic [31:0] f, input logic [31:0] p, input bit c);
        logic [31:0] ph;
        en = e; ftw_we = we; ftw_in = f; poff_in = p; phase_clr = c;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            hist_en[cyc] = 1'b0;
            m_acc = '0;
            m_ftw = '0;
        end else begin
            ph = m_acc + p;
            hist_en[cyc] = e;
            hist_k[cyc]  = int'(ph[31:24]);
            if (c)      m_acc = '0;
            else if (e) m_acc = m_acc + m_ftw;
            if (we)     m_ftw = f;
        end
        #1;
        if (!rst) begin
            ev = 1'b0; es = 0; ec = 0;
        end else if (cyc >= 2 && hist_en[cyc-2]) begin
            ev = 1'b1;
            es = ref_sin(hist_k[cyc-2]);
            ec = ref_cos(hist_k[cyc-2]);
        end else begin
            ev = 1'b0;
        end
        chk("valid", 32'(out_valid), 32'(ev));
        chk("sin",   32'(sin_out),   es);
        chk("cos",   32'(cos_out),   ec);
    endtask

    task automatic run(input int n, input logic [31:0] p);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, p, 1'b0);
    endtask

    initial begin
        int          lat;
        logic [15:0] gap_pat;
        rst = 1'b0; en = 1'b0; ftw_we = 1'b0; ftw_in = '0; poff_in = '0; phase_clr = 1'b0;
        for (int i = 0; i < 4096; i++) begin hist_en[i] = 1'b0; hist_k[i] = 0; end

        // Reset held with en toggling.
        #2;
        chk("rst_sin",   32'(sin_out),   0);
        chk("rst_cos",   32'(cos_out),   0);
        chk("rst_valid", 32'(out_valid), 0);
        for (int i = 0; i < 5; i++) step(i[0], 1'b1, 32'h0100_0000, 32'h0, 1'b0);

        // Release, load ftw, measure first-sample latency.
        rst = 1'b1;
        step(1'b0, 1'b1, 32'h0100_0000, 32'h0, 1'b0);
        lat = 0;
        do begin
            step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            lat++;
        end while (!out_valid && lat < 10);
        chk("latency", lat, 3);
        chk("k0_sin", 32'(sin_out), 0);
        chk("k0_cos", 32'(cos_out), 32767);
        run(1, 32'h0);  chk("k1_sin", 32'(sin_out), 804);
        run(1, 32'h0);  chk("k2_sin", 32'(sin_out), 1608);
        run(62, 32'h0); chk("k64_sin", 32'(sin_out), 32767);  chk("k64_cos", 32'(cos_out), 0);
        run(64, 32'h0); chk("k128_sin", 32'(sin_out), 0);     chk("k128_cos", 32'(cos_out), -32767);
        run(64, 32'h0); chk("k192_sin", 32'(sin_out), -32767);
        run(64, 32'h0); chk("wrap_sin", 32'(sin_out), 0);     chk("wrap_cos", 32'(cos_out), 32767);

        // Quarter-turn steps with an eighth-turn offset.
        step(1'b0, 1'b1, 32'h4000_0000, 32'h2000_0000, 1'b1);
        run(3, 32'h2000_0000); chk("poff_s0", 32'(sin_out), 23170);
        run(1, 32'h2000_0000); chk("poff_s1", 32'(sin_out), 23170);
        run(1, 32'h2000_0000); chk("poff_s2", 32'(sin_out), -23170);
        run(1, 32'h2000_0000); chk("poff_s3", 32'(sin_out), -23170);

        // Tuning word change mid-run.
        step(1'b0, 1'b1, 32'h0100_0000, 32'h0, 1'b1);
        run(5, 32'h0);
        step(1'b1, 1'b1, 32'h0200_0000, 32'h0, 1'b0);
        run(10, 32'h0);

        // Clear with en: fourth clock after the clear restarts at zero phase.
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1);
        run(3, 32'h0);
        chk("clr_restart", 32'(sin_out), 0);

        // en gaps must reappear unchanged on out_valid.
        gap_pat = 16'b1011_0011_1000_1101;
        for (int i = 0; i < 16; i++) step(gap_pat[i], 1'b0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        // Randomized traffic with a mid-stream reset.
        for (int i = 0; i < 1200; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom, $urandom,
                 $urandom_range(0, 31) == 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, $urandom, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom, $urandom,
                 $urandom_range(0, 31) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
